// File: rtl/sp_pkg.sv
// sp_pkg: opcodes, FSM states and instruction field helpers for sp_param_core
package sp_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_MOV  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_MUL  = 4'd10,
    OP_OUT  = 4'd11,
    OP_ADDI = 4'd12
  } opcode_e;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_e;

  // instruction layout is {op[3:0], rd[raw], rs[raw], imm[dw]}, MSB to LSB
  function automatic logic [3:0] op_of(input logic [63:0] ins, input int raw, input int dw);
    return 4'(ins >> (2 * raw + dw));
  endfunction

  function automatic logic [31:0] rd_of(input logic [63:0] ins, input int raw, input int dw);
    return 32'((ins >> (raw + dw)) & ((64'd1 << raw) - 64'd1));
  endfunction

  function automatic logic [31:0] rs_of(input logic [63:0] ins, input int raw, input int dw);
    return 32'((ins >> dw) & ((64'd1 << raw) - 64'd1));
  endfunction

  function automatic logic [31:0] imm_of(input logic [63:0] ins, input int dw);
    return 32'(ins & ((64'd1 << dw) - 64'd1));
  endfunction
endpackage

// File: rtl/sp_mul_seq.sv
// sp_mul_seq: iterative shift-add unsigned multiplier, one multiplier bit per cycle over DW cycles
module sp_mul_seq #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            done,
  output logic [2*DW-1:0] prod
);
  localparam int CW = $clog2(DW);

  logic [2*DW-1:0] acc_q, mcand_q;
  logic [DW-1:0]   mplier_q;
  logic [CW-1:0]   cnt_q;
  logic            run_q;

  // prod already folds in the current bit, so it is the full product in the done cycle
  always_comb begin
    prod = acc_q + (mplier_q[0] ? mcand_q : '0);
    done = run_q && (cnt_q == CW'(DW - 1));
  end

  // capture operands on start, then retire one multiplier bit per cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{DW{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= prod;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/sp_param_core.sv
// sp_param_core: parametrised streaming processor core; define SP_SAT_EN for saturating ADD/ADDI/SUB/MUL
module sp_param_core
  import sp_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [4+2*$clog2(NREG)+DW-1:0]  instruction,
  output logic                            busy,
  output logic                            out_valid,
  output logic [DW-1:0]                   out
);
  localparam int RAW = $clog2(NREG);
  localparam int IW  = 4 + 2 * RAW + DW;
  localparam int SW  = $clog2(DW);
`ifdef SP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  state_e          state_q;
  logic            busy_q, out_valid_q;
  logic [DW-1:0]   out_q;
  logic [IW-1:0]   instr_q;
  logic [DW-1:0]   r_q [NREG];

  opcode_e         op;
  logic [3:0]      in_op;
  logic [RAW-1:0]  rd, rs, in_rd, in_rs;
  logic [DW-1:0]   imm, a, b, res_d, mul_d;
  logic [DW:0]     sum, dif;
  logic            wr_d, accept, mul_start, mul_done;
  logic [2*DW-1:0] prod;

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

  // decode both the incoming and the latched instruction
  always_comb begin
    in_op     = op_of(64'(instruction), RAW, DW);
    in_rd     = RAW'(rd_of(64'(instruction), RAW, DW));
    in_rs     = RAW'(rs_of(64'(instruction), RAW, DW));
    accept    = in_valid && !busy_q && state_q == IDLE;
    mul_start = accept && in_op == OP_MUL;
    op        = opcode_e'(op_of(64'(instr_q), RAW, DW));
    rd        = RAW'(rd_of(64'(instr_q), RAW, DW));
    rs        = RAW'(rs_of(64'(instr_q), RAW, DW));
    imm       = DW'(imm_of(64'(instr_q), DW));
  end

  // single-cycle ALU; the extra carry/borrow bit drives optional saturation
  always_comb begin
    a     = r_q[rd];
    b     = r_q[rs];
    sum   = {1'b0, a} + {1'b0, op == OP_ADDI ? imm : b};
    dif   = {1'b0, a} - {1'b0, b};
    mul_d = (SAT && |prod[2*DW-1:DW]) ? '1 : prod[DW-1:0];
    wr_d  = 1'b1;
    res_d = a;
    case (op)
      OP_LDI:          res_d = imm;
      OP_MOV:          res_d = b;
      OP_ADD, OP_ADDI: res_d = (SAT && sum[DW]) ? '1 : sum[DW-1:0];
      OP_SUB:          res_d = (SAT && dif[DW]) ? '0 : dif[DW-1:0];
      OP_AND:          res_d = a & b;
      OP_OR:           res_d = a | b;
      OP_XOR:          res_d = a ^ b;
      OP_SHL:          res_d = a << imm[SW-1:0];
      OP_SHR:          res_d = a >> imm[SW-1:0];
      default:         wr_d  = 1'b0;
    endcase
  end

  // operands come straight from the register file, which is stable while idle
  sp_mul_seq #(.DW(DW)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (r_q[in_rd]),
    .b     (r_q[in_rs]),
    .done  (mul_done),
    .prod  (prod)
  );

  // control FSM with register file writeback and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      instr_q     <= '0;
      for (int i = 0; i < NREG; i++) r_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          instr_q <= instruction;
          busy_q  <= 1'b1;
          state_q <= in_op == OP_MUL ? MUL : EXEC;
        end
        EXEC: begin
          if (wr_d) r_q[rd] <= res_d;
          if (op == OP_OUT) begin
            out_q       <= r_q[rd];
            out_valid_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        MUL: if (mul_done) begin
          r_q[rd] <= mul_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_param_core.sv
// tb_sp_param_core: directed checks of sp_param_core at DW=8, NREG=4; follows SP_SAT_EN
module tb_sp_param_core;
  localparam int DW = 8;
  localparam int IW = 16;
`ifdef SP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] instruction = '0;
  logic          busy, out_valid;
  logic [DW-1:0] out;
  int            n_chk = 0;
  int            n_pass = 0;

  sp_param_core #(.DW(DW), .NREG(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .instruction (instruction),
    .busy        (busy),
    .out_valid   (out_valid),
    .out         (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int k = 0;
    while (busy && k < 50) begin
      tick;
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
    wait_idle;
    in_valid    = 1'b1;
    instruction = {op, rd, rs, imm};
    tick;
    in_valid    = 1'b0;
  endtask

  task automatic out_chk(input string tag, input logic [1:0] rd, input logic [7:0] exp);
    issue(4'd11, rd, 2'd0, 8'd0);
    check({tag, "_vld_n1"}, out_valid, 0);
    tick;
    check(tag, out, exp);
    check({tag, "_vld_n2"}, out_valid, 1);
    tick;
    check({tag, "_vld_n3"}, out_valid, 0);
    check({tag, "_hold"}, out, exp);
  endtask

  task automatic count_busy(input string tag, input int exp);
    int n = 0;
    while (busy && n < 50) begin
      n++;
      tick;
    end
    check(tag, n, exp);
  endtask

  initial begin
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_ovld", out_valid, 0);
    check("rst_out", out, 0);
    rst = 1'b1;
    tick;

    issue(4'd1, 2'd1, 2'd0, 8'd200);
    issue(4'd1, 2'd2, 2'd0, 8'd100);
    issue(4'd3, 2'd1, 2'd2, 8'd0);
    out_chk("add", 2'd1, SAT ? 8'd255 : 8'd44);

    issue(4'd1, 2'd0, 2'd0, 8'd5);
    issue(4'd1, 2'd3, 2'd0, 8'd9);
    issue(4'd4, 2'd0, 2'd3, 8'd0);
    out_chk("sub", 2'd0, SAT ? 8'd0 : 8'd252);
    issue(4'd12, 2'd0, 2'd0, 8'd4);
    out_chk("addi", 2'd0, SAT ? 8'd4 : 8'd0);

    issue(4'd1, 2'd1, 2'd0, 8'd12);
    issue(4'd1, 2'd2, 2'd0, 8'd11);
    issue(4'd10, 2'd1, 2'd2, 8'd0);
    count_busy("mul_busy", 8);
    out_chk("mul", 2'd1, 8'd132);
    issue(4'd1, 2'd3, 2'd0, 8'd20);
    issue(4'd10, 2'd3, 2'd3, 8'd0);
    count_busy("mul_sq_busy", 8);
    out_chk("mul_sq", 2'd3, SAT ? 8'd255 : 8'd144);

    issue(4'd1, 2'd2, 2'd0, 8'h81);
    issue(4'd8, 2'd2, 2'd0, 8'd1);
    out_chk("shl", 2'd2, 8'h02);
    issue(4'd1, 2'd2, 2'd0, 8'h81);
    issue(4'd9, 2'd2, 2'd0, 8'd7);
    out_chk("shr", 2'd2, 8'h01);
    issue(4'd14, 2'd2, 2'd1, 8'hff);
    check("rsv_busy1", busy, 1);
    tick;
    check("rsv_busy2", busy, 0);
    out_chk("rsv_r2", 2'd2, 8'h01);
    out_chk("rsv_r1", 2'd1, 8'd132);

    issue(4'd1, 2'd0, 2'd0, 8'hf0);
    issue(4'd1, 2'd3, 2'd0, 8'h3c);
    issue(4'd5, 2'd0, 2'd3, 8'd0);
    out_chk("and", 2'd0, 8'h30);
    issue(4'd6, 2'd0, 2'd3, 8'd0);
    out_chk("or", 2'd0, 8'h3c);
    issue(4'd7, 2'd0, 2'd0, 8'd0);
    out_chk("xor_self", 2'd0, 8'h00);
    issue(4'd2, 2'd0, 2'd1, 8'd0);
    out_chk("mov", 2'd0, 8'd132);

    rst = 1'b0;
    tick;
    rst = 1'b1;
    issue(4'd1, 2'd1, 2'd0, 8'd3);
    issue(4'd1, 2'd2, 2'd0, 8'd5);
    issue(4'd10, 2'd1, 2'd2, 8'd0);
    tick;
    in_valid    = 1'b1;
    instruction = {4'd1, 2'd0, 2'd0, 8'h55};
    tick;
    in_valid    = 1'b0;
    wait_idle;
    out_chk("drop_r0", 2'd0, 8'd0);
    out_chk("drop_r1", 2'd1, 8'd15);

    issue(4'd1, 2'd1, 2'd0, 8'd7);
    issue(4'd1, 2'd2, 2'd0, 8'd6);
    issue(4'd10, 2'd1, 2'd2, 8'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    check("mrst_busy", busy, 0);
    check("mrst_ovld", out_valid, 0);
    check("mrst_out", out, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    check("mrst_idle", busy, 0);
    out_chk("mrst_r1", 2'd1, 8'd0);
    out_chk("mrst_r2", 2'd2, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sp_param_core.md
Name: sp_param_core

Overview:
Parametrised successor to the team's 8-bit simple processor core. Same streaming interface: instructions in via in_valid/busy, results out via out_valid/out. Generalised in data width and register-file depth. Adds a multi-cycle sequential multiplier, immediate-add, shifts and an optional saturating mode. Sits under the standard TESTBED/PATTERN harness as a drop-in core.

Parameters:
DW, 8, data width of registers and out
NREG, 4, number of general registers (power of 2, >=2)
RAW (localparam), $clog2(NREG), register address width
IW (localparam), 4+2*RAW+DW, instruction width (16 at defaults)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  instruction present this cycle
instruction  input  IW  {op[3:0], rd[RAW], rs[RAW], imm[DW]} MSB→LSB
busy  output  1  registered; core cannot accept
out_valid  output  1  registered; out valid this cycle (1-cycle pulse)
out  output  DW  registered output data

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-low, on rst. rst=0 at any rising edge: all R[i]=0, state IDLE, busy=0, out_valid=0, out=0. Reset mid-MUL aborts the multiply with no register write.
- Accept: rising edge with in_valid=1 and busy=0 in IDLE. Instruction is latched.
- in_valid while busy=1 is silently dropped: no state change, no error.
- States:
  - IDLE: on accept, go to EXEC, or to MUL if op=MUL.
  - EXEC: one cycle, then IDLE.
  - MUL: DW cycles, then IDLE.
- Timing, accept at edge N:
  - Single-cycle ops: busy=1 during cycle N+1. Writeback at end of N+1. busy=0 in N+2. Throughput is one instruction per 2 cycles.
  - MUL: busy=1 for cycles N+1..N+DW. Writeback at end of N+DW. busy=0 in N+DW+1.
  - OUT: out=R[rd] and out_valid=1 during cycle N+2 only. Otherwise out_valid=0 and out holds its last value.
- Opcodes:
  - 0 NOP; 1 LDI rd<=imm; 2 MOV rd<=R[rs]
  - 3 ADD rd<=R[rd]+R[rs]; 4 SUB rd<=R[rd]-R[rs]; 12 ADDI rd<=R[rd]+imm
  - 5 AND; 6 OR; 7 XOR (rd<=R[rd] op R[rs])
  - 8 SHL and 9 SHR, logical, rd<=R[rd] shifted by imm[$clog2(DW)-1:0]
  - 10 MUL rd<=R[rd]*R[rs]; 11 OUT
  - 13–15 reserved, executed as NOP (busy 1 cycle)
- Arithmetic is unsigned, DW bits; default is wrap modulo 2^DW.
- MUL is shift-add, one multiplier bit per cycle over 2*DW-bit partial product. Result is product[DW-1:0], or the saturated value when the optional feature is enabled.
- rd==rs is legal; operands are sampled at EXEC/MUL start.
- MUL operands are captured into the sub-module at start; R is unchanged until writeback.

Optional Feature:
SP_SAT_EN: ADD/ADDI/MUL clamp to 2^DW-1 on overflow; SUB clamps to 0 on underflow. Undefined: all arithmetic wraps modulo 2^DW. Logic, shift, LDI and MOV are unaffected either way.

Decomposition:
- Package sp_pkg holds:
  - opcode enum (4-bit, values above)
  - state enum {IDLE, EXEC, MUL}
  - instruction field-slice helper functions parametrised by DW/RAW
- Sub-module sp_mul_seq: iterative DW-cycle unsigned multiplier.
  - Ports: clk, rst, start, a, b, done, prod[2*DW]
  - done pulses in the DW-th cycle.
  - The core applies saturation, not sp_mul_seq.

Test Plan:
- LDI R1,200; LDI R2,100; ADD R1,R2; OUT R1 → out=44 (without SP_SAT_EN) / 255 (with); out_valid high exactly 1 cycle, 2 cycles after OUT accept.
- LDI R0,5; LDI R3,9; SUB R0,R3; OUT R0 → 252 (wrap) / 0 (sat); ADDI R0,imm=4 then OUT → 0 (wrap 252+4) / 4 (sat).
- LDI R1,12; LDI R2,11; MUL R1,R2 → busy high exactly 8 consecutive cycles; OUT R1 → 132; LDI R3,20; MUL R3,R3; OUT R3 → 144 / 255 (sat).
- LDI R2,0x81; SHL R2 imm=1; OUT → 0x02; LDI R2,0x81; SHR imm=7; OUT → 0x01; opcode 14 → busy 1 cycle, no register changes.
- Drive LDI R0,0x55 while busy=1 during MUL → dropped; subsequent OUT R0 returns prior value (0 after reset).
- Assert rst=0 on 3rd MUL cycle → next cycle busy=0, out_valid=0, out=0; OUT R1 → 0; no late writeback occurs.
